// File: rtl/layer_scheduler.sv
// Sequences NUM_LAYERS layer engines one at a time over the shared MultAdd unit and memory bus.
// Optional watchdog on the RUN phase is built when LAYER_SCHED_WDOG_EN is defined.
module layer_scheduler #(
   parameter int  NUM_LAYERS = 3,
   parameter int  DW         = 1024,
   parameter int  AW         = 12,
   parameter int  MIN_RUN    = 8,
   parameter int  TIMEOUT    = 4095,
   localparam int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                     clk,
   input  logic                     iRst_n,
   input  logic                     start,
   input  logic [NUM_LAYERS-1:0]    eng_done,
   input  logic [NUM_LAYERS-1:0]    eng_ovf,
   input  logic [NUM_LAYERS*AW-1:0] eng_addr,
   input  logic [NUM_LAYERS*DW-1:0] eng_d1,
   input  logic [NUM_LAYERS*DW-1:0] eng_d2,
   output logic [NUM_LAYERS-1:0]    eng_ena,
   output logic [NUM_LAYERS-1:0]    eng_rst_n,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mau_d1,
   output logic [DW-1:0]            mau_d2,
   output logic [LW-1:0]            cur_layer,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic                     err
);

   localparam int              CMAX      = (MIN_RUN > TIMEOUT) ? MIN_RUN : TIMEOUT;
   localparam int              CW        = $clog2(CMAX + 1);
   localparam logic [CW-1:0]   MIN_RUN_C = CW'(MIN_RUN);
   localparam logic [LW-1:0]   LAST      = LW'(NUM_LAYERS - 1);
`ifdef LAYER_SCHED_WDOG_EN
   localparam logic [CW-1:0]   TIMEOUT_C = CW'(TIMEOUT);
`endif

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LRST = 3'd1,
      S_RUN  = 3'd2,
      S_NEXT = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   state_t        state;
   logic [CW-1:0] run_cnt;
   logic          sel_done;
   logic          sel_ovf;
   logic          active;

   function automatic logic [NUM_LAYERS-1:0] onehot(input logic [LW-1:0] idx);
      logic [NUM_LAYERS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (idx == LW'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   assign active = (state == S_LRST) || (state == S_RUN) || (state == S_NEXT);

   // Only the engine addressed by cur_layer reaches the shared buses; idle buses read as zero.
   always_comb begin
      mem_addr = '0;
      mau_d1   = '0;
      mau_d2   = '0;
      sel_done = 1'b0;
      sel_ovf  = 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (cur_layer == LW'(i)) begin
            sel_done = eng_done[i];
            sel_ovf  = eng_ovf[i];
            if (active) begin
               mem_addr = eng_addr[i*AW +: AW];
               mau_d1   = eng_d1[i*DW +: DW];
               mau_d2   = eng_d2[i*DW +: DW];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!iRst_n) begin
         state     <= S_IDLE;
         cur_layer <= '0;
         eng_ena   <= '0;
         eng_rst_n <= '1;
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         run_cnt   <= '0;
`ifdef LAYER_SCHED_WDOG_EN
         err       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LRST;
                  cur_layer <= '0;
                  overflow  <= 1'b0;
                  busy      <= 1'b1;
                  eng_ena   <= onehot('0);
                  eng_rst_n <= ~onehot('0);
`ifdef LAYER_SCHED_WDOG_EN
                  err       <= 1'b0;
`endif
               end
            end
            S_LRST: begin
               state     <= S_RUN;
               eng_rst_n <= '1;
               run_cnt   <= '0;
            end
            S_RUN: begin
               if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
               // Engines come out of reset with done already high, so done only counts after MIN_RUN.
               if (sel_done && (run_cnt >= MIN_RUN_C)) begin
                  state <= S_NEXT;
               end
`ifdef LAYER_SCHED_WDOG_EN
               else if (run_cnt == TIMEOUT_C) begin
                  err     <= 1'b1;
                  eng_ena <= '0;
                  state   <= S_FIN;
               end
`endif
            end
            S_NEXT: begin
               overflow <= overflow | sel_ovf;
               if (cur_layer == LAST) begin
                  eng_ena <= '0;
                  state   <= S_FIN;
               end else begin
                  cur_layer <= cur_layer + 1'b1;
                  eng_ena   <= onehot(cur_layer + 1'b1);
                  eng_rst_n <= ~onehot(cur_layer + 1'b1);
                  state     <= S_LRST;
               end
            end
            S_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state   <= S_IDLE;
               eng_ena <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifndef LAYER_SCHED_WDOG_EN
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: vector table of full sequences plus hand sequences
// for bus muxing, start-while-busy, mid-sequence reset and (when built in) the watchdog.
module tb_layer_scheduler;

   localparam int NL = 3;
   localparam int DW = 1024;
   localparam int AW = 12;
   localparam int LW = 2;

   logic             clk;
   logic             iRst_n;
   logic             start;
   logic [NL-1:0]    eng_done;
   logic [NL-1:0]    eng_ovf;
   logic [NL*AW-1:0] eng_addr;
   logic [NL*DW-1:0] eng_d1;
   logic [NL*DW-1:0] eng_d2;
   logic [NL-1:0]    eng_ena;
   logic [NL-1:0]    eng_rst_n;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mau_d1;
   logic [DW-1:0]    mau_d2;
   logic [LW-1:0]    cur_layer;
   logic             busy;
   logic             done;
   logic             overflow;
   logic             err;

   int n_checks = 0;
   int n_fail   = 0;

   layer_scheduler #(
      .NUM_LAYERS(NL), .DW(DW), .AW(AW), .MIN_RUN(8), .TIMEOUT(50)
   ) dut (
      .clk(clk), .iRst_n(iRst_n), .start(start),
      .eng_done(eng_done), .eng_ovf(eng_ovf), .eng_addr(eng_addr),
      .eng_d1(eng_d1), .eng_d2(eng_d2), .eng_ena(eng_ena), .eng_rst_n(eng_rst_n),
      .mem_addr(mem_addr), .mau_d1(mau_d1), .mau_d2(mau_d2), .cur_layer(cur_layer),
      .busy(busy), .done(done), .overflow(overflow), .err(err)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // engine model: counts enabled cycles since its reset; done once count reaches k-1
   int cnt[NL] = '{1000, 1000, 1000};
   int k[NL]   = '{20, 30, 12};
   bit ovf1_cfg = 1'b0;
   bit ovf2_cfg = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < NL; i++) begin
         if (!eng_rst_n[i]) cnt[i] <= 0;
         else if (eng_ena[i] && cnt[i] < 1000000) cnt[i] <= cnt[i] + 1;
      end
   end

   always_comb begin
      eng_done = '0;
      for (int i = 0; i < NL; i++) eng_done[i] = (cnt[i] >= k[i] - 1);
      eng_ovf    = '0;
      eng_ovf[1] = ovf1_cfg & eng_ena[1];
      eng_ovf[2] = ovf2_cfg & eng_ena[0];
   end

   // scoreboard
   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver: one full sequence, measuring edges from the start-accept edge to done
   task automatic run_seq(input int k0, input int k1, input int k2, input bit o1, input bit o2,
                          input int exp_cyc, input logic exp_ovf, input logic exp_err,
                          input int exp_n, input logic [8:0] exp_order);
      logic [2:0] exp_q[$];
      logic [2:0] last_ena;
      logic [8:0] packed_order;
      int         cyc;
      bit         multi;
      k[0] = k0; k[1] = k1; k[2] = k2;
      ovf1_cfg = o1; ovf2_cfg = o2;
      exp_q.delete();
      last_ena = '0;
      multi = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      cyc = 1;
      if (eng_ena != 3'b000) begin
         exp_q.push_back(eng_ena);
         last_ena = eng_ena;
      end
      while (!done && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
         if ((eng_ena & (eng_ena - 3'd1)) != 3'b000) multi = 1'b1;
         if (eng_ena != 3'b000 && eng_ena != last_ena) begin
            exp_q.push_back(eng_ena);
            last_ena = eng_ena;
         end
      end
      chk("done_seen", done, 1'b1);
      chk("latency", DW'(cyc), DW'(exp_cyc));
      chk("overflow", overflow, exp_ovf);
      chk("err", err, exp_err);
      chk("busy_at_done", busy, 1'b0);
      chk("ena_onehot", multi, 1'b0);
      chk("ena_count", DW'(exp_q.size()), DW'(exp_n));
      packed_order = '0;
      for (int i = 0; i < exp_q.size() && i < 3; i++) packed_order[i*3 +: 3] = exp_q[i];
      chk("ena_order", packed_order, exp_order);
      @(posedge clk);
      #1;
      chk("done_pulse_width", done, 1'b0);
      chk("ena_idle", eng_ena, 3'b000);
      ovf1_cfg = 1'b0; ovf2_cfg = 1'b0;
   endtask

   typedef struct {
      int   k0, k1, k2;
      bit   o1, o2;
      int   exp_cyc;
      logic exp_ovf;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int guard;
      vecs[0] = '{k0: 20, k1: 30, k2: 12, o1: 0, o2: 0, exp_cyc: 70, exp_ovf: 1'b0};
      vecs[1] = '{k0: 20, k1: 1,  k2: 12, o1: 0, o2: 0, exp_cyc: 49, exp_ovf: 1'b0};
      vecs[2] = '{k0: 10, k1: 10, k2: 10, o1: 0, o2: 0, exp_cyc: 38, exp_ovf: 1'b0};
      vecs[3] = '{k0: 9,  k1: 9,  k2: 9,  o1: 0, o2: 0, exp_cyc: 35, exp_ovf: 1'b0};
      vecs[4] = '{k0: 20, k1: 30, k2: 12, o1: 1, o2: 1, exp_cyc: 70, exp_ovf: 1'b1};
      vecs[5] = '{k0: 20, k1: 30, k2: 12, o1: 0, o2: 1, exp_cyc: 70, exp_ovf: 1'b0};

      start  = 1'b0;
      iRst_n = 1'b0;
      eng_addr = {12'h7ff, 12'h480, 12'h123};
      eng_d1   = {{128{8'h33}}, {128{8'h11}}, {128{8'h22}}};
      eng_d2   = {{128{8'h66}}, {128{8'h55}}, {128{8'h44}}};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ena", eng_ena, 3'b000);
      chk("rst_eng_rst_n", eng_rst_n, 3'b111);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_cur_layer", cur_layer, 2'd0);
      @(negedge clk);
      iRst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_mem_addr", mem_addr, 12'h000);
      chk("idle_mau_d1", mau_d1, '0);
      chk("idle_mau_d2", mau_d2, '0);

      // bus muxing, start while busy, reset mid-layer-1
      k[0] = 20; k[1] = 30; k[2] = 12;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      guard = 0;
      while (!(eng_ena == 3'b001 && eng_rst_n == 3'b111) && guard < 200) begin
         @(posedge clk); #1; guard++;
      end
      chk("l0_run_reached", DW'(guard < 200), DW'(1));
      chk("l0_mem_addr", mem_addr, 12'h123);
      chk("l0_mau_d1", mau_d1, {128{8'h22}});
      guard = 0;
      while (!(eng_ena == 3'b010 && eng_rst_n == 3'b111) && guard < 200) begin
         @(posedge clk); #1; guard++;
      end
      chk("l1_run_reached", DW'(guard < 200), DW'(1));
      chk("l1_mem_addr", mem_addr, 12'h480);
      chk("l1_mau_d1", mau_d1, {128{8'h11}});
      chk("l1_mau_d2", mau_d2, {128{8'h55}});
      chk("l1_cur_layer", cur_layer, 2'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("start_busy_ignored_ena", eng_ena, 3'b010);
      chk("start_busy_ignored_busy", busy, 1'b1);
      @(negedge clk);
      iRst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_ena", eng_ena, 3'b000);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_eng_rst_n", eng_rst_n, 3'b111);
      chk("midrst_mem_addr", mem_addr, 12'h000);
      chk("midrst_cur_layer", cur_layer, 2'd0);
      @(negedge clk);
      iRst_n = 1'b1;

`ifdef LAYER_SCHED_WDOG_EN
      // engine 0 never finishes: watchdog ends the sequence with only layer 0 enabled
      run_seq(1000000, 30, 12, 0, 0, 54, 1'b0, 1'b1, 1, 9'b000_000_001);
`endif

      for (int v = 0; v < 6; v++) begin
         run_seq(vecs[v].k0, vecs[v].k1, vecs[v].k2, vecs[v].o1, vecs[v].o2,
                 vecs[v].exp_cyc, vecs[v].exp_ovf, 1'b0, 3, 9'b100_010_001);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
